// File: rtl/capture_mem_reader.sv
// capture_mem_reader: reads one captured frame from acquisition RAM onto a valid/ready stream.
// Optional feature: define CMR_DECIMATE_EN for a 1<<decim_shift address stride.
module capture_mem_reader #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] pre_trig,
  input  logic [15:0]       frame_len,
  input  logic [2:0]        decim_shift,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_clk_en,
  output logic              mem_cs,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]     stride_q, stride_d;
  logic [15:0]           issue_cnt_q, issue_cnt_d;
  logic [15:0]           deliver_cnt_q, deliver_cnt_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [PW:0]           occ_q, occ_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]     fifo_q [FIFO_DEPTH];

  logic [CW-1:0]         inflight;
  logic                  issue;
  logic                  push;
  logic                  pop;

`ifdef CMR_DECIMATE_EN
  logic [ADDR_W-1:0] stride_in;
  assign stride_in = ADDR_W'(1) << decim_shift;
`else
  logic [ADDR_W-1:0] stride_in;
  logic              unused_decim;
  assign stride_in    = ADDR_W'(1);
  assign unused_decim = ^decim_shift;
`endif

  // Count reads still travelling through the RAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(pipe_q[i]);
    end
  end

  // Issue only with a FIFO slot reserved for every outstanding read.
  assign issue = (state_q == S_STREAM) && (issue_cnt_q != 16'd0) &&
                 ((CW'(occ_q) + inflight) < CW'(FIFO_DEPTH));
  assign push  = pipe_q[RD_LATENCY-1];
  assign pop   = out_valid & out_ready;

  assign mem_address = rd_addr_q;
  assign mem_read    = issue;
  assign mem_cs      = issue;
  assign mem_clk_en  = issue;

  assign out_valid = (occ_q != '0);
  assign out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && (deliver_cnt_q == 16'd1);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  // Next-state logic for the readout FSM, counters and FIFO pointers.
  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    stride_d      = stride_q;
    issue_cnt_d   = issue_cnt_q;
    deliver_cnt_d = deliver_cnt_q;
    pipe_d        = RD_LATENCY'({pipe_q, issue});
    occ_d         = occ_q + (PW+1)'(push) - (PW+1)'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_LOAD;
          rd_addr_d     = start_addr - pre_trig;
          stride_d      = stride_in;
          issue_cnt_d   = frame_len;
          deliver_cnt_d = frame_len;
        end
      end
      S_LOAD: begin
        state_d = (deliver_cnt_q == 16'd0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (issue) begin
          rd_addr_d   = rd_addr_q + stride_q;
          issue_cnt_d = issue_cnt_q - 16'd1;
        end
        if (pop) begin
          deliver_cnt_d = deliver_cnt_q - 16'd1;
          if (deliver_cnt_q == 16'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      pipe_d   = '0;
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rd_addr_q     <= '0;
      stride_q      <= '0;
      issue_cnt_q   <= '0;
      deliver_cnt_q <= '0;
      pipe_q        <= '0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      stride_q      <= stride_d;
      issue_cnt_q   <= issue_cnt_d;
      deliver_cnt_q <= deliver_cnt_d;
      pipe_q        <= pipe_d;
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Capture returning RAM data into the prefetch FIFO.
  always_ff @(posedge clk_50) begin
    if (push) fifo_q[wr_ptr_q] <= mem_rd_data;
  end

endmodule
